// File: rtl/pulse_measure.sv
// Measures the two high widths and the low gap of a double pulse on an asynchronous
// input, in sys_clk cycles, with saturation, gap timeout and an arm/disarm control.
module pulse_measure #(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pulse_in,
    input  logic             arm,
    input  logic [CNT_W-1:0] gap_timeout,
    output logic [CNT_W-1:0] meas_width1,
    output logic [CNT_W-1:0] meas_gap,
    output logic [CNT_W-1:0] meas_width2,
    output logic             meas_valid,
    output logic             meas_ovf,
    output logic             meas_err,
    output logic             busy,
    output logic [15:0]      meas_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, W1 = 2'd1, GAP = 2'd2, W2 = 2'd3} state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_q, s2_q, s3_q;
    logic [2:0]       sv_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] w1_q, w1_d, gap_q, gap_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] res_w1_q, res_w1_d, res_gap_q, res_gap_d, res_w2_q, res_w2_d;
    logic             valid_q, valid_d, err_q, err_d, ovfo_q, ovfo_d, busy_q;
    logic [15:0]      count_q, count_d;
    logic             rise, fall, cnt_max;
    logic [CNT_W-1:0] cnt_inc;

    // sv_q marks when s3 holds a post-reset sample, so a level already high at
    // reset release does not look like a rising edge.
    assign rise    = sv_q[2] & s2_q & ~s3_q;
    assign fall    = sv_q[2] & ~s2_q & s3_q;
    assign cnt_max = &cnt_q;
    assign cnt_inc = cnt_max ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w1_d      = w1_q;
        gap_d     = gap_q;
        ovf_d     = ovf_q;
        res_w1_d  = res_w1_q;
        res_gap_d = res_gap_q;
        res_w2_d  = res_w2_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        ovfo_d    = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (rise && arm) begin
                    state_d = W1;
                    cnt_d   = CNT_ONE;
                    ovf_d   = 1'b0;
                end
            end
            W1: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (fall) begin
                    state_d = GAP;
                    w1_d    = cnt_q;
                    cnt_d   = CNT_ONE;
                end else if (s2_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_max) ovf_d = 1'b1;
                end
            end
            GAP: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (rise) begin
                    state_d = W2;
                    gap_d   = cnt_q;
                    cnt_d   = CNT_ONE;
                end else if (gap_timeout != '0 && cnt_q == gap_timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (!s2_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_max) ovf_d = 1'b1;
                end
            end
            W2: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (fall) begin
                    state_d   = IDLE;
                    res_w1_d  = w1_q;
                    res_gap_d = gap_q;
                    res_w2_d  = cnt_q;
                    valid_d   = 1'b1;
                    ovfo_d    = ovf_q;
                    count_d   = count_q + 16'd1;
                end else if (s2_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_max) ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            sv_q      <= 3'b000;
            state_q   <= IDLE;
            cnt_q     <= '0;
            w1_q      <= '0;
            gap_q     <= '0;
            ovf_q     <= 1'b0;
            res_w1_q  <= '0;
            res_gap_q <= '0;
            res_w2_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovfo_q    <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            s1_q      <= pulse_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            sv_q      <= {sv_q[1:0], 1'b1};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w1_q      <= w1_d;
            gap_q     <= gap_d;
            ovf_q     <= ovf_d;
            res_w1_q  <= res_w1_d;
            res_gap_q <= res_gap_d;
            res_w2_q  <= res_w2_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ovfo_q    <= ovfo_d;
            busy_q    <= (state_d != IDLE);
            count_q   <= count_d;
        end
    end

    assign meas_width1 = res_w1_q;
    assign meas_gap    = res_gap_q;
    assign meas_width2 = res_w2_q;
    assign meas_valid  = valid_q;
    assign meas_ovf    = ovfo_q;
    assign meas_err    = err_q;
    assign busy        = busy_q;
    assign meas_count  = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pulse_measure.sv
// Self-checking bench for pulse_measure: expected results are queued when a double
// pulse is driven and checked by a monitor when meas_valid strobes.
module tb_pulse_measure;

    localparam int CNT_W = 16;
    localparam int W     = 3 * CNT_W + 1;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             pulse_in = 1'b0;
    logic             arm = 1'b0;
    logic [CNT_W-1:0] gap_timeout = '0;
    logic [CNT_W-1:0] meas_width1, meas_gap, meas_width2;
    logic             meas_valid, meas_ovf, meas_err, busy;
    logic [15:0]      meas_count;
    logic [1:0]       dbg_state;

    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     exp_v;
    logic [W-1:0]     got_v;
    logic [CNT_W-1:0] last_w1 = '0, last_gap = '0, last_w2 = '0;
    logic [15:0]      exp_count = 16'd0;
    int               asserts = 0;
    int               fails = 0;

    pulse_measure #(.CNT_W(CNT_W)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pulse_in    (pulse_in),
        .arm         (arm),
        .gap_timeout (gap_timeout),
        .meas_width1 (meas_width1),
        .meas_gap    (meas_gap),
        .meas_width2 (meas_width2),
        .meas_valid  (meas_valid),
        .meas_ovf    (meas_ovf),
        .meas_err    (meas_err),
        .busy        (busy),
        .meas_count  (meas_count),
        .dbg_state   (dbg_state)
    );

    // 50 MHz
    always #10 sys_clk = ~sys_clk;

    function automatic logic [CNT_W-1:0] sat(input int n);
        return (n > 65535) ? 16'hFFFF : n[CNT_W-1:0];
    endfunction

    // Scoreboard monitor, sampling 1 ns after each rising edge.
    always @(posedge sys_clk) begin
        #1;
        if (meas_valid === 1'b1) begin
            asserts++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: got w1=%0d gap=%0d w2=%0d, expected no strobe",
                         meas_width1, meas_gap, meas_width2);
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {meas_width1, meas_gap, meas_width2, meas_ovf};
                if (got_v !== exp_v) begin
                    fails++;
                    $display("FAIL result: got w1=%0d gap=%0d w2=%0d ovf=%0b, expected w1=%0d gap=%0d w2=%0d ovf=%0b",
                             got_v[W-1 -: CNT_W], got_v[2*CNT_W -: CNT_W], got_v[CNT_W:1], got_v[0],
                             exp_v[W-1 -: CNT_W], exp_v[2*CNT_W -: CNT_W], exp_v[CNT_W:1], exp_v[0]);
                end
                last_w1  = exp_v[W-1 -: CNT_W];
                last_gap = exp_v[2*CNT_W -: CNT_W];
                last_w2  = exp_v[CNT_W:1];
            end
        end
        if (meas_err === 1'b1 || meas_ovf === 1'b1) begin
            asserts++;
            if ((meas_err === 1'b1 && meas_valid === 1'b1) || (meas_ovf === 1'b1 && meas_valid !== 1'b1)) begin
                fails++;
                $display("FAIL strobe_excl: got valid=%0b err=%0b ovf=%0b, expected err/valid exclusive and ovf only with valid",
                         meas_valid, meas_err, meas_ovf);
            end
        end
    end

    task automatic send_pulse(input int h1, input int l, input int h2);
        exp_q.push_back({sat(h1), sat(l), sat(h2), (h1 > 65535 || l > 65535 || h2 > 65535)});
        exp_count = exp_count + 16'd1;
        @(negedge sys_clk);
        pulse_in = 1'b1;
        repeat (h1) @(negedge sys_clk);
        pulse_in = 1'b0;
        repeat (l) @(negedge sys_clk);
        pulse_in = 1'b1;
        repeat (h2) @(negedge sys_clk);
        pulse_in = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge sys_clk);
        ok = (exp_q.size() == 0);
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        asserts++;
        if ({meas_width1, meas_gap, meas_width2} !== '0) begin
            fails++;
            $display("FAIL reset_results: got %h, expected 0", {meas_width1, meas_gap, meas_width2});
        end
        asserts++;
        if ({meas_valid, meas_ovf, meas_err, busy} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got valid/ovf/err/busy=%b, expected 0000", {meas_valid, meas_ovf, meas_err, busy});
        end
        asserts++;
        if (meas_count !== 16'd0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_count_state: got count=%0d state=%0d, expected 0 0", meas_count, dbg_state);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_basic;
        int n;
        bit ok;
        arm = 1'b1;
        gap_timeout = '0;
        repeat (2) @(negedge sys_clk);
        send_pulse(5, 3, 7);
        n = 0;
        while (n < 10 && meas_valid !== 1'b1) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        asserts++;
        if (n != 3) begin
            fails++;
            $display("FAIL valid_latency: got %0d edges, expected 3", n);
        end
        wait_drain(20, ok);
        asserts++;
        if (!ok) begin
            fails++;
            $display("FAIL basic_drain: got %0d pending results, expected 0", exp_q.size());
        end
        asserts++;
        if (meas_count !== exp_count || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_count: got count=%0d busy=%0b, expected count=%0d busy=0", meas_count, busy, exp_count);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        for (int k = 0; k < 5; k++) begin
            send_pulse($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12));
            repeat (4) @(negedge sys_clk);
        end
        wait_drain(50, ok);
        asserts++;
        if (!ok || meas_count !== exp_count) begin
            fails++;
            $display("FAIL back_to_back: got pending=%0d count=%0d, expected pending=0 count=%0d",
                     exp_q.size(), meas_count, exp_count);
        end
    endtask

    task automatic test_timeout;
        int n;
        bit got;
        gap_timeout = 16'd10;
        @(negedge sys_clk);
        pulse_in = 1'b1;
        repeat (4) @(negedge sys_clk);
        pulse_in = 1'b0;
        n = 0;
        got = 0;
        while (n < 40 && !got) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (meas_err === 1'b1) got = 1;
        end
        asserts++;
        if (!got || n != 13) begin
            fails++;
            $display("FAIL timeout_edge: got err=%0b at edge %0d, expected err at edge 13", got, n);
        end
        @(posedge sys_clk);
        #1;
        asserts++;
        if (meas_err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_after: got err=%0b busy=%0b, expected 0 0", meas_err, busy);
        end
        asserts++;
        if (meas_width1 !== last_w1 || meas_gap !== last_gap || meas_width2 !== last_w2 || meas_count !== exp_count) begin
            fails++;
            $display("FAIL timeout_hold: got %0d/%0d/%0d count=%0d, expected %0d/%0d/%0d count=%0d",
                     meas_width1, meas_gap, meas_width2, meas_count, last_w1, last_gap, last_w2, exp_count);
        end
        gap_timeout = '0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_ovf;
        bit ok;
        send_pulse(70000, 2, 3);
        wait_drain(40, ok);
        asserts++;
        if (!ok) begin
            fails++;
            $display("FAIL ovf_drain: got %0d pending, expected 0", exp_q.size());
        end
        send_pulse(4, 4, 4);
        wait_drain(40, ok);
        asserts++;
        if (!ok || meas_count !== exp_count) begin
            fails++;
            $display("FAIL ovf_clear: got pending=%0d count=%0d, expected pending=0 count=%0d",
                     exp_q.size(), meas_count, exp_count);
        end
    endtask

    task automatic test_disarm;
        bit ok;
        @(negedge sys_clk);
        pulse_in = 1'b1;
        repeat (5) @(negedge sys_clk);
        pulse_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        pulse_in = 1'b1;
        repeat (4) @(negedge sys_clk);
        asserts++;
        if (dbg_state !== 2'd3) begin
            fails++;
            $display("FAIL disarm_in_w2: got state=%0d, expected 3", dbg_state);
        end
        arm = 1'b0;
        @(posedge sys_clk);
        #1;
        asserts++;
        if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL disarm_idle: got state=%0d busy=%0b, expected 0 0", dbg_state, busy);
        end
        @(negedge sys_clk);
        repeat (2) @(negedge sys_clk);
        pulse_in = 1'b0;
        repeat (6) @(negedge sys_clk);
        asserts++;
        if (meas_count !== exp_count || meas_width1 !== last_w1) begin
            fails++;
            $display("FAIL disarm_hold: got count=%0d w1=%0d, expected count=%0d w1=%0d",
                     meas_count, meas_width1, exp_count, last_w1);
        end
        arm = 1'b1;
        repeat (3) @(negedge sys_clk);
        send_pulse(2, 2, 2);
        wait_drain(20, ok);
        asserts++;
        if (!ok) begin
            fails++;
            $display("FAIL disarm_rearm: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        @(negedge sys_clk);
        pulse_in = 1'b1;
        repeat (3) @(negedge sys_clk);
        pulse_in = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        asserts++;
        if ({meas_width1, meas_gap, meas_width2, meas_valid, meas_ovf, meas_err, busy} !== '0 || meas_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid: got w1=%0d gap=%0d w2=%0d busy=%0b count=%0d, expected all 0",
                     meas_width1, meas_gap, meas_width2, busy, meas_count);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        exp_count = 16'd0;
        last_w1 = '0;
        last_gap = '0;
        last_w2 = '0;
        repeat (4) @(negedge sys_clk);
        send_pulse(4, 6, 8);
        wait_drain(20, ok);
        asserts++;
        if (!ok || meas_count !== 16'd1) begin
            fails++;
            $display("FAIL reset_mid_after: got pending=%0d count=%0d, expected pending=0 count=1", exp_q.size(), meas_count);
        end
    endtask

    task automatic test_prehigh;
        bit ok;
        arm = 1'b0;
        @(negedge sys_clk);
        pulse_in = 1'b1;
        repeat (4) @(negedge sys_clk);
        arm = 1'b1;
        repeat (4) @(negedge sys_clk);
        pulse_in = 1'b0;
        repeat (5) @(negedge sys_clk);
        asserts++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL prehigh_ignored: got busy=%0b, expected 0", busy);
        end
        send_pulse(3, 3, 3);
        wait_drain(20, ok);
        asserts++;
        if (!ok || meas_count !== exp_count) begin
            fails++;
            $display("FAIL prehigh_valid: got pending=%0d count=%0d, expected pending=0 count=%0d",
                     exp_q.size(), meas_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_ovf();
        test_disarm();
        test_reset_mid();
        test_prehigh();
        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
